// File: rtl/bist_signature_checker.sv
// rtl/bist_signature_checker.sv - LFSR pattern source and MISR compactor with golden-signature check
// Drives pseudo-random stimulus into a CUT and judges its compacted response on one pass bit.
module bist_signature_checker #(
   parameter int          PI_WIDTH     = 178,
   parameter int          PO_WIDTH     = 123,
   parameter int          NUM_PATTERNS = 1024,
   parameter int          CUT_LATENCY  = 0,
   parameter logic [31:0] LFSR_SEED    = 32'h00000001
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [PO_WIDTH-1:0] golden_sig,
   input  logic [PO_WIDTH-1:0] cut_po,
   output logic [PI_WIDTH-1:0] cut_pi,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [PO_WIDTH-1:0] signature,
   output logic [15:0]         pattern_cnt
);

   localparam logic [31:0] LFSR_MASK  = 32'h80200003;
   localparam int          DL         = (CUT_LATENCY > 0) ? CUT_LATENCY : 1;
   localparam logic        NO_LAT     = (CUT_LATENCY == 0);
   localparam logic [15:0] LAST_PAT   = 16'(NUM_PATTERNS - 1);
   localparam logic [2:0]  LAST_FLUSH = (CUT_LATENCY > 0) ? 3'(CUT_LATENCY - 1) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [31:0]         lfsr_q, lfsr_d;
   logic [PI_WIDTH-1:0] pi_q, pi_d;
   logic [PO_WIDTH-1:0] misr_q, misr_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [2:0]          flush_q, flush_d;
   logic                pass_q, pass_d;
   logic [DL-1:0]       vld_q, vld_d;
   logic                applying;
   logic                cap;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_MASK : 32'h0);
   endfunction

   // Copy k of the LFSR is rotated left by k, so bit j of copy k is lfsr[(j-k) mod 32].
   function automatic logic [PI_WIDTH-1:0] expand(input logic [31:0] l);
      logic [PI_WIDTH-1:0] v;
      logic [4:0]          idx;
      v = '0;
      for (int b = 0; b < PI_WIDTH; b++) begin
         idx  = 5'((b % 32) - (b / 32));
         v[b] = l[idx];
      end
      return v;
   endfunction

   function automatic logic [PO_WIDTH-1:0] misr_step(input logic [PO_WIDTH-1:0] m,
                                                     input logic [PO_WIDTH-1:0] r);
      logic [PO_WIDTH-1:0] n;
      n[0] = m[PO_WIDTH-1] ^ r[0];
      n[1] = m[0] ^ m[PO_WIDTH-1] ^ r[1];
      for (int i = 2; i < PO_WIDTH; i++) begin
         n[i] = m[i-1] ^ r[i];
      end
      return n;
   endfunction

   assign applying = (state_q == S_RUN);
   // With zero latency the response is captured alongside its pattern; otherwise it trails in vld_q.
   assign cap      = (NO_LAT && applying) || vld_q[DL-1];

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      pi_d    = pi_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
      flush_d = flush_q;
      pass_d  = pass_q;
      vld_d   = NO_LAT ? '0 : DL'({vld_q, applying});
      if (cap) begin
         misr_d = misr_step(misr_q, cut_po);
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               lfsr_d  = LFSR_SEED;
               pi_d    = expand(LFSR_SEED);
               misr_d  = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == LAST_PAT) begin
               flush_d = '0;
               state_d = NO_LAT ? S_DONE : S_FLUSH;
            end else begin
               lfsr_d = lfsr_step(lfsr_q);
               pi_d   = expand(lfsr_d);
            end
         end
         S_FLUSH: begin
            flush_d = flush_q + 3'd1;
            if (flush_q == LAST_FLUSH) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            pass_d  = (misr_q == golden_sig);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lfsr_q  <= LFSR_SEED;
         pi_q    <= '0;
         misr_q  <= '0;
         cnt_q   <= '0;
         flush_q <= '0;
         pass_q  <= 1'b0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         pi_q    <= pi_d;
         misr_q  <= misr_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         pass_q  <= pass_d;
         vld_q   <= vld_d;
      end
   end

   // The final MISR value is already settled in DONE, so pass is shown live there and held afterwards.
   assign pass        = (state_q == S_DONE) ? (misr_q == golden_sig) : pass_q;
   assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
   assign done        = (state_q == S_DONE);
   assign cut_pi      = pi_q;
   assign signature   = misr_q;
   assign pattern_cnt = cnt_q;

endmodule
